// File: rtl/tick_meter_pkg.sv
// Shared types and constants for the strobe period meter and its helpers.
package tick_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  // Averaging window is 2**AVG_SHIFT periods.
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a one-cycle rising-edge pulse generator.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   prev_vld_q;

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // value its neighbour held before this edge, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      vld_q      <= '0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      prev_vld_q <= vld_q[SYNC_STAGES-1];
    end
  end

  // The reset zeros in the chain are not real samples; a strobe held high
  // across reset release must not look like a rising edge.
  assign edge_o = prev_vld_q & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle period of an asynchronous strobe; results leave over valid/ready.
// Define TICK_METER_AVG_EN to report the mean of every 4 consecutive periods instead.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter  int MAX_PERIOD  = 50000000,
  parameter  int SYNC_STAGES = 2,
  localparam int WIDTH       = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_in,
  output logic [WIDTH-1:0] meas_data,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_PERIOD);

  logic             edge_pulse;
  meter_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             per_done;
  logic             res_vld;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] meas_data_q;
  logic             meas_valid_q;
  logic             overrun_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .strobe_i(strobe_in),
    .edge_o  (edge_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    per_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_pulse) begin
          state_d = ST_ARMED;
          cnt_d   = WIDTH'(1);
        end
      end
      ST_ARMED, ST_MEASURE: begin
        if (edge_pulse) begin
          per_done = 1'b1;
          cnt_d    = WIDTH'(1);
          state_d  = ST_MEASURE;
        end else if (cnt_q == MAX_CNT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef TICK_METER_AVG_EN
  logic [WIDTH+1:0]     acc_q, acc_d, acc_sum;
  logic [AVG_SHIFT-1:0] nper_q, nper_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      nper_q <= '0;
    end else begin
      acc_q  <= acc_d;
      nper_q <= nper_d;
    end
  end

  always_comb begin
    acc_sum  = acc_q + {2'b00, cnt_q};
    acc_d    = acc_q;
    nper_d   = nper_q;
    res_vld  = 1'b0;
    res_data = WIDTH'(acc_sum >> AVG_SHIFT);
    if (per_done) begin
      if (nper_q == '1) begin
        res_vld = 1'b1;
        acc_d   = '0;
        nper_d  = '0;
      end else begin
        acc_d  = acc_sum;
        nper_d = nper_q + 1'b1;
      end
    end else if (timeout_d) begin
      acc_d  = '0;
      nper_d = '0;
    end
  end
`else
  assign res_vld  = per_done;
  assign res_data = cnt_q;
`endif

  // A result landing on the acceptance cycle replaces the consumed one cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_data_q  <= '0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (res_vld) begin
        meas_data_q  <= res_data;
        meas_valid_q <= 1'b1;
        if (meas_valid_q && !meas_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (meas_valid_q && meas_ready) begin
        meas_valid_q <= 1'b0;
      end
    end
  end

  assign meas_data  = meas_data_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the period, in `clk` cycles, of a strobe arriving from outside the `clk` domain, such as a camera frame or line strobe or another divider's tick, and reports each result over a valid/ready handshake. It is the receiving end of the tick-generation path: the clock divider turns a cycle count into periodic ticks, and this block turns periodic ticks back into a cycle count. It sits between the camera/strobe inputs and the capture control and status logic.

## Interface
- `MAX_PERIOD`, default 50000000: largest measurable period in `clk` cycles; longer gaps raise a timeout.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `strobe_in`; minimum 2.
- `clk` input, 1 bit: single system clock; all logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `strobe_in` input, 1 bit: asynchronous strobe; each rising edge marks one period boundary.
- `meas_data` output, `WIDTH` bits: measured period in `clk` cycles.
- `meas_valid` output, 1 bit: `meas_data` holds an unconsumed result.
- `meas_ready` input, 1 bit: consumer accepts the result.
- `overrun` output, 1 bit: sticky; a result was overwritten while unconsumed.
- `timeout` output, 1 bit: one-cycle pulse when no edge arrived within `MAX_PERIOD` cycles.

## Operation
- `WIDTH` = `$clog2(MAX_PERIOD+1)`. The cycle counter is `WIDTH` bits and never wraps.
- `strobe_in` passes through the `SYNC_STAGES`-flop synchronizer and then a one-flop rising-edge detector, which produces a one-cycle pulse `edge`.
- The FSM has three states: IDLE, ARMED and MEASURE.
  - IDLE, the reset state: on the first `edge`, go to ARMED and load `cnt`=1.
  - ARMED and MEASURE count periods back-to-back, so every `edge` closes one period and opens the next.
    - On a cycle with no `edge`: `cnt`<=`cnt`+1.
    - On `edge`: the result is `cnt`, then `cnt`<=1 and the state becomes MEASURE.
- A strobe with period N `clk` cycles yields result N.
- Timeout: if `cnt`==`MAX_PERIOD` with no `edge`, pulse `timeout`, discard the partial count and go to IDLE. The next `edge` re-arms without producing a result.
- Output register:
  - A result loads `meas_data` and sets `meas_valid`.
  - `meas_valid` clears on the cycle where `meas_valid`&&`meas_ready`.
  - If a new result arrives while `meas_valid`&&!`meas_ready`: overwrite `meas_data`, keep `meas_valid`=1, set `overrun`.
  - If a new result arrives in the same cycle as acceptance: the old result is consumed, the new one loads, `meas_valid` stays 1, and `overrun` is not set.
- `overrun` clears only on `rst`.
- Reset mid-measurement: all state is lost immediately, the FSM is in IDLE, and the first edge after release produces no result.

## Timing
- Reset values:
  - `meas_data`=0, `meas_valid`=0, `overrun`=0, `timeout`=0.
  - FSM = IDLE, `cnt`=0.
  - All synchronizer flops = 0, so a `strobe_in` held high through reset produces no edge.
- Latency: a rising edge of `strobe_in` first sampled at clk edge k gives `edge` high in cycle k+`SYNC_STAGES`, and `meas_valid`/`meas_data` update at k+`SYNC_STAGES`+1.
- `timeout` pulses the cycle after `cnt` reaches `MAX_PERIOD`.
- Minimum resolvable period is 2 cycles, because the edge detector needs a low sample between edges.
- `meas_data` is stable whenever `meas_valid`=1 and no new result arrives.

## Configuration
- `TICK_METER_AVG_EN` defined:
  - Each result is the mean of 4 consecutive periods: `sum`>>2, with a `WIDTH`+2-bit accumulator.
  - The first result appears after 4 complete periods following arming.
  - A timeout clears the accumulator and the period count.
- `TICK_METER_AVG_EN` undefined: every single period is reported, and no accumulator exists.

## Structure
- Shared package `tick_meter_pkg`:
  - FSM state typedef (IDLE/ARMED/MEASURE).
  - The `AVG_SHIFT`=2 constant.
- One sub-module `sync_edge_detect` (parameter `SYNC_STAGES`): synchronizer plus rising-edge pulse. It is reused elsewhere for the camera strobes.

## Test plan
- Drive `strobe_in` from a clock divider with MODULO=10 and hold `meas_ready`=1:
  - No result for the first edge.
  - Then `meas_data`=10 on every result, `overrun`=0.
- Use a strobe with period 7 and hold `meas_ready`=0 for 3 results → `meas_valid` stays 1, `meas_data`=7, `overrun`=1.
- `MAX_PERIOD`=100 with the strobe stopped after arming → `timeout` pulses once, 100 cycles after the last edge. The next edge produces no result and the following one reports the correct period.
- Assert `rst` mid-period with `meas_valid`=1 → all outputs return to their reset values immediately. After release, the first edge produces no result.
- Alternate periods 8 and 12:
  - With `TICK_METER_AVG_EN` defined: `meas_data`=10 after each group of 4.
  - Without it: results alternate 8, 12.
- Hold `strobe_in` high through reset release → no `edge` and no result until the strobe goes low then high.
